glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Parametrised successor to the single-shot offset/duration counter pair that drives `power_ctrl`.
- Stores up to NUM_GLITCHES (offset, duration) pairs, waits in an armed state for a trigger edge, then plays the pulses back to back on `power_select`.
- Each offset is measured from the trigger (pulse 0) or from the end of the previous pulse (pulse i>0).
- Sits between `command_processor`, which writes config and arms it, and the target power switch. Replaces `offset_counter` and `duration_counter`.

Parameters:
- NUM_GLITCHES, 4: number of stored pulse slots (≥1).
- CNT_WIDTH, 32: width of each offset and duration value and of the internal down-counter.
- IDX_WIDTH, 2: width of slot index; must satisfy 2**IDX_WIDTH ≥ NUM_GLITCHES.
- IDLE_LEVEL, 1'b1: `power_select` level when not glitching. The glitch level is ~IDLE_LEVEL.

Ports:
- clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_sel  in  1  0 = write offset, 1 = write duration.
- cfg_idx  in  IDX_WIDTH  slot index for the write.
- cfg_data  in  CNT_WIDTH  value written.
- num_pulses  in  IDX_WIDTH+1  pulses to play; sampled at arm.
- arm  in  1  one-cycle request to arm.
- abort  in  1  one-cycle request to cancel any activity.
- trigger  in  1  synchronous trigger; the rising edge starts the sequence.
- power_select  out  1  glitch output to the power mux.
- armed  out  1  high in ARMED.
- busy  out  1  high in OFFSET or GLITCH.
- done  out  1  one-cycle pulse when the last pulse ends.
- pulse_idx  out  IDX_WIDTH  current slot being played.

Behaviour:

Reset:
- All offset/duration registers clear to 0.
- State is IDLE.
- `power_select` = IDLE_LEVEL; `armed`, `busy`, `done` = 0; `pulse_idx` = 0.
- The previous-trigger register resets to 1, so a trigger already high at reset release is not an edge.

Config writes:
- Accepted only in IDLE or DONE.
- Ignored if cfg_idx ≥ NUM_GLITCHES.
- The write takes effect at the next clock edge.

Trigger edge:
- Edge = trigger & ~trigger_q, where trigger_q is a 1-cycle registered copy.

FSM states: IDLE, ARMED, OFFSET, GLITCH, DONE.
- IDLE/DONE → ARMED on `arm` when num_pulses ≠ 0.
  - Latch n = min(num_pulses, NUM_GLITCHES).
  - `arm` with num_pulses = 0 is ignored.
- ARMED → OFFSET on trigger edge. Load cnt = offset[0], pulse_idx = 0.
- OFFSET:
  - If cnt = 0: go to GLITCH and load cnt = duration[pulse_idx].
  - Else cnt decrements.
- GLITCH:
  - `power_select` = ~IDLE_LEVEL for exactly duration[i] cycles, registered output.
  - When the count ends:
    - If pulse_idx = n-1: go to DONE, pulsing `done` for 1 cycle.
    - Otherwise increment pulse_idx and go to OFFSET with cnt = offset[pulse_idx+1].
- DONE → IDLE after one cycle, unless `arm` arrives that same cycle.

Timing:
- Trigger sampled high at edge T (low at T-1): `power_select` changes at edge T+1+offset[0]+1.
- The fixed 2-cycle latency is a contract; the bench measures it.
- Offset 0 for i>0 gives a 1-cycle gap minimum; the gap is offset[i]+1 cycles.

Boundary cases:
- duration[i] = 0: slot is skipped. No glitch; proceeds directly to the next OFFSET or to DONE.
- Counter never wraps: the decrement is guarded at 0.
- `abort` in any state → IDLE next cycle, `power_select` = IDLE_LEVEL immediately registered, no `done`. Abort beats `arm` if simultaneous.
- `arm` while ARMED/OFFSET/GLITCH is ignored.
- Trigger edges after leaving ARMED are ignored.
- rst_n low mid-glitch: `power_select` returns to IDLE_LEVEL asynchronously.

Decomposition:
- Shared package `glitch_pkg`:
  - state enum (IDLE, ARMED, OFFSET, GLITCH, DONE);
  - CFG_SEL_OFFSET/CFG_SEL_DURATION constants;
  - default CNT_WIDTH.
- Natural sub-module: `glitch_slot_regs`, the NUM_GLITCHES × 2 register file with write port and combinational read by index. The FSM and counter stay in the top.

Test Plan:
- Single pulse: write offset[0]=5, duration[0]=3, num_pulses=1, arm, trigger rise at T → `power_select` low at edges T+7..T+9, `done` at T+10, `busy` low after.
- Three pulses: offsets {2,4,0}, durations {1,2,5}, n=3 → low windows of 1, 2 and 5 cycles with gaps of 5 and 1 cycles; `pulse_idx` steps 0→1→2.
- Zero duration: durations {3,0,2}, n=3 → exactly two low windows; the slot-1 offset is still counted.
- Abort mid-glitch: duration 100, assert `abort` at cycle 10 of the glitch → `power_select` high next cycle, no `done`, state IDLE. A config write is then accepted.
- Guards:
  - cfg write during GLITCH: slot contents unchanged.
  - `arm` with num_pulses=0: stays IDLE.
  - num_pulses=7 with NUM_GLITCHES=4: plays 4 pulses.
- Reset/trigger: trigger held high through reset release and then arm → no start until trigger falls and rises again. rst_n pulsed low mid-offset → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and constants for the multi-pulse glitch sequencer.
package glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_OFFSET = 3'd2,
    ST_GLITCH = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic CFG_SEL_OFFSET   = 1'b0;
  localparam logic CFG_SEL_DURATION = 1'b1;

  localparam int DEFAULT_CNT_WIDTH = 32;

endpackage

// File: rtl/glitch_slot_regs.sv
// Per-slot offset/duration storage with one write port and two
// independent combinational read ports (offset and duration).
module glitch_slot_regs
  import glitch_pkg::*;
#(
  parameter int NUM_GLITCHES = 4,
  parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter int IDX_WIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 sel,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [CNT_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0] off_idx,
  input  logic [IDX_WIDTH-1:0] dur_idx,
  output logic [CNT_WIDTH-1:0] rd_offset,
  output logic [CNT_WIDTH-1:0] rd_duration
);

  logic [CNT_WIDTH-1:0] offset_r   [NUM_GLITCHES];
  logic [CNT_WIDTH-1:0] duration_r [NUM_GLITCHES];

  // Slot register file; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GLITCHES; i++) begin
        offset_r[i]   <= '0;
        duration_r[i] <= '0;
      end
    end else if (we && (int'(wr_idx) < NUM_GLITCHES)) begin
      if (sel == CFG_SEL_DURATION) begin
        duration_r[wr_idx] <= wr_data;
      end else begin
        offset_r[wr_idx] <= wr_data;
      end
    end
  end

  // Read ports return zero for indices beyond the populated slots.
  always_comb begin
    rd_offset   = '0;
    rd_duration = '0;
    if (int'(off_idx) < NUM_GLITCHES) begin
      rd_offset = offset_r[off_idx];
    end else begin
      rd_offset = '0;
    end
    if (int'(dur_idx) < NUM_GLITCHES) begin
      rd_duration = duration_r[dur_idx];
    end else begin
      rd_duration = '0;
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Plays up to NUM_GLITCHES (offset, duration) pulses on power_select after
// a trigger rising edge; all outputs are registered from the current state.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int   NUM_GLITCHES = 4,
  parameter int   CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter int   IDX_WIDTH    = 2,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [IDX_WIDTH-1:0] cfg_idx,
  input  logic [CNT_WIDTH-1:0] cfg_data,
  input  logic [IDX_WIDTH:0]   num_pulses,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trigger,
  output logic                 power_select,
  output logic                 armed,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_WIDTH-1:0] pulse_idx
);

  localparam logic [IDX_WIDTH:0] NUM_G = (IDX_WIDTH+1)'(NUM_GLITCHES);

  state_t               state_r, state_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
  logic [IDX_WIDTH-1:0] idx_r, idx_s;
  logic [IDX_WIDTH:0]   n_r, n_s;
  logic                 trigger_q_r;
  logic                 power_select_r, armed_r, busy_r, done_r;
  logic [IDX_WIDTH-1:0] pulse_idx_r;

  logic                 trig_edge_s, arm_ok_s, last_s, cfg_open_s;
  logic [IDX_WIDTH-1:0] idx_next_s, off_rd_idx_s;
  logic [IDX_WIDTH:0]   n_clamp_s;
  logic [CNT_WIDTH-1:0] rd_offset_s, rd_duration_s;

  assign trig_edge_s  = trigger & ~trigger_q_r;
  assign arm_ok_s     = arm && (num_pulses != '0);
  assign n_clamp_s    = (num_pulses > NUM_G) ? NUM_G : num_pulses;
  assign last_s       = ({1'b0, idx_r} == (n_r - (IDX_WIDTH+1)'(1)));
  assign idx_next_s   = idx_r + IDX_WIDTH'(1);
  assign cfg_open_s   = (state_r == ST_IDLE) || (state_r == ST_DONE);
  // While armed the offset port must point at slot 0; otherwise at the next slot.
  assign off_rd_idx_s = (state_r == ST_ARMED) ? '0 : idx_next_s;

  glitch_slot_regs #(
    .NUM_GLITCHES(NUM_GLITCHES),
    .CNT_WIDTH   (CNT_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_slots (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (cfg_we && cfg_open_s),
    .sel        (cfg_sel),
    .wr_idx     (cfg_idx),
    .wr_data    (cfg_data),
    .off_idx    (off_rd_idx_s),
    .dur_idx    (idx_r),
    .rd_offset  (rd_offset_s),
    .rd_duration(rd_duration_s)
  );

  // State, counter and slot pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      n_r         <= '0;
      trigger_q_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      n_r         <= n_s;
      trigger_q_r <= trigger;
    end
  end

  // Next-state logic; zero-duration slots are skipped without a GLITCH visit.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    n_s     = n_r;
    if (abort) begin
      state_s = ST_IDLE;
      idx_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm_ok_s) begin
            state_s = ST_ARMED;
            n_s     = n_clamp_s;
            idx_s   = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (trig_edge_s) begin
            state_s = ST_OFFSET;
            cnt_s   = rd_offset_s;
            idx_s   = '0;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_OFFSET: begin
          if (cnt_r != '0) begin
            cnt_s = cnt_r - CNT_WIDTH'(1);
          end else if (rd_duration_s != '0) begin
            state_s = ST_GLITCH;
            cnt_s   = rd_duration_s;
          end else if (last_s) begin
            state_s = ST_DONE;
          end else begin
            idx_s = idx_next_s;
            cnt_s = rd_offset_s;
          end
        end
        ST_GLITCH: begin
          if (cnt_r > CNT_WIDTH'(1)) begin
            cnt_s = cnt_r - CNT_WIDTH'(1);
          end else if (last_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_OFFSET;
            idx_s   = idx_next_s;
            cnt_s   = rd_offset_s;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs; abort forces the idle values on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      power_select_r <= IDLE_LEVEL;
      armed_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pulse_idx_r    <= '0;
    end else begin
      power_select_r <= (!abort && (state_r == ST_GLITCH)) ? ~IDLE_LEVEL : IDLE_LEVEL;
      armed_r        <= !abort && (state_r == ST_ARMED);
      busy_r         <= !abort && ((state_r == ST_OFFSET) || (state_r == ST_GLITCH));
      done_r         <= !abort && (state_r == ST_DONE);
      pulse_idx_r    <= idx_r;
    end
  end

  assign power_select = power_select_r;
  assign armed        = armed_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pulse_idx    = pulse_idx_r;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised bench for glitch_sequencer: pulse windows are predicted from the
// offset/duration timing rules and compared cycle by cycle.
module tb_glitch_sequencer;
  import glitch_pkg::*;

  localparam int NG = 4;
  localparam int CW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [IW:0]   num_pulses = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger = 1'b0;
  logic          power_select, armed, busy, done;
  logic [IW-1:0] pulse_idx;

  int checks = 0;
  int errors = 0;

  // Model state: configured slots and predicted low windows (cycles after trigger edge).
  int m_off[NG];
  int m_dur[NG];
  int m_start[NG];
  int m_n;
  int m_done;

  always #5 clk = ~clk;

  glitch_sequencer #(
    .NUM_GLITCHES(NG), .CNT_WIDTH(CW), .IDX_WIDTH(IW), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .num_pulses(num_pulses),
    .arm(arm), .abort(abort), .trigger(trigger), .power_select(power_select),
    .armed(armed), .busy(busy), .done(done), .pulse_idx(pulse_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic sel, input int idx, input int val);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = IW'(idx); cfg_data = CW'(val);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm_seq(input int n);
    num_pulses = (IW+1)'(n); arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Raise trigger; on return the trigger edge (cycle 0) has just been taken.
  task automatic fire();
    trigger = 1'b1;
    tick();
  endtask

  // Pulse 0 begins 2+offset cycles after the trigger; each later pulse
  // begins offset+1 cycles after the previous one ends; done follows the last.
  task automatic model_plan(input int n_req);
    int t;
    m_n = (n_req > NG) ? NG : n_req;
    t = 2 + m_off[0];
    for (int i = 0; i < m_n; i++) begin
      if (i > 0) t = t + m_off[i] + 1;
      m_start[i] = t;
      t = t + m_dur[i];
    end
    m_done = t;
  endtask

  function automatic logic exp_low(input int c);
    for (int i = 0; i < m_n; i++)
      if (c >= m_start[i] && c < m_start[i] + m_dur[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_idx(input int c);
    int r = 0;
    for (int i = 0; i < m_n; i++)
      if (c >= m_start[i] - m_off[i] - 1) r = i;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    checks++;
    if ({power_select, armed, busy, done, pulse_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++; $display("FAIL reset_outputs got %b exp 1000_00", {power_select, armed, busy, done, pulse_idx});
    end
    for (int i = 0; i < NG; i++) begin m_off[i] = 0; m_dur[i] = 0; end
    model_plan(1);
    arm_seq(1); tick(); fire();
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (power_select !== 1'b1 || done !== (c == m_done)) begin
        errors++; $display("FAIL reset_slots c=%0d ps=%b done=%b exp ps=1 done=%b", c, power_select, done, c == m_done);
      end
    end
    trigger = 1'b0;
  endtask

  task automatic test_sequences();
    int d_off [4][NG] = '{'{5, 0, 0, 0}, '{2, 4, 0, 0}, '{1, 3, 2, 0}, '{1, 0, 2, 1}};
    int d_dur [4][NG] = '{'{3, 0, 0, 0}, '{1, 2, 5, 0}, '{3, 0, 2, 0}, '{2, 1, 1, 3}};
    int d_n   [4]     = '{1, 3, 3, 7};
    int n;
    logic exp_ps;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NG; i++) begin
        m_off[i] = (k < 4) ? d_off[k][i] : int'($urandom_range(0, 6));
        m_dur[i] = (k < 4) ? d_dur[k][i] : int'($urandom_range(0, 6));
        write_cfg(CFG_SEL_OFFSET, i, m_off[i]);
        write_cfg(CFG_SEL_DURATION, i, m_dur[i]);
      end
      n = (k < 4) ? d_n[k] : int'($urandom_range(1, 7));
      model_plan(n);
      arm_seq(n); tick();
      checks++;
      if (armed !== 1'b1) begin errors++; $display("FAIL seq%0d armed got %b exp 1", k, armed); end
      repeat ($urandom_range(0, 3)) tick();
      fire();
      for (int c = 1; c <= m_done + 2; c++) begin
        trigger = 1'($urandom_range(0, 1));
        tick();
        exp_ps = ~exp_low(c);
        checks++;
        if (power_select !== exp_ps || done !== (c == m_done) || busy !== (c < m_done)
            || armed !== 1'b0 || pulse_idx !== IW'(exp_idx(c))) begin
          errors++;
          $display("FAIL seq%0d c=%0d ps/done/busy/armed/idx got %b%b%b%b/%0d exp %b%b%b0/%0d",
                   k, c, power_select, done, busy, armed, pulse_idx,
                   exp_ps, c == m_done, c < m_done, exp_idx(c));
        end
      end
      trigger = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic bad = 1'b0;
    write_cfg(CFG_SEL_OFFSET, 0, 2); write_cfg(CFG_SEL_DURATION, 0, 100);
    arm_seq(1); tick(); fire();
    repeat (13) tick();
    checks++;
    if (power_select !== 1'b0) begin errors++; $display("FAIL abort_pre ps got %b exp 0", power_select); end
    abort = 1'b1; tick(); abort = 1'b0; trigger = 1'b0;
    checks++;
    if (power_select !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_now ps/busy/done got %b%b%b exp 100", power_select, busy, done);
    end
    for (int c = 0; c < 110; c++) begin
      tick();
      if (done !== 1'b0 || power_select !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_after activity after abort got 1 exp 0"); end
    write_cfg(CFG_SEL_OFFSET, 0, 1); write_cfg(CFG_SEL_DURATION, 0, 1);
    arm_seq(1); tick(); fire();
    tick(); tick(); tick();
    checks++;
    if (power_select !== 1'b0) begin errors++; $display("FAIL abort_cfg c=3 ps got %b exp 0", power_select); end
    tick();
    checks++;
    if (power_select !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL abort_cfg c=4 ps/done got %b%b exp 11", power_select, done);
    end
    trigger = 1'b0; tick(); tick();
  endtask

  task automatic test_guards();
    int first_low = -1;
    int low_cnt = 0;
    write_cfg(CFG_SEL_OFFSET, 0, 0); write_cfg(CFG_SEL_DURATION, 0, 6);
    arm_seq(1); tick(); fire();
    repeat (3) tick();
    write_cfg(CFG_SEL_DURATION, 0, 1); write_cfg(CFG_SEL_OFFSET, 0, 3);
    trigger = 1'b0;
    repeat (6) tick();
    arm_seq(1); tick(); fire();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (power_select === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
    end
    checks++;
    if (first_low != 2 || low_cnt != 6) begin
      errors++; $display("FAIL cfg_locked first_low=%0d len=%0d exp 2/6", first_low, low_cnt);
    end
    trigger = 1'b0; tick();
    arm_seq(0); tick();
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL arm_zero armed got %b exp 0", armed); end
    fire(); tick(); tick();
    checks++;
    if (busy !== 1'b0 || power_select !== 1'b1) begin
      errors++; $display("FAIL arm_zero busy/ps got %b%b exp 01", busy, power_select);
    end
    trigger = 1'b0; tick();
  endtask

  task automatic test_trigger_reset();
    int pos [2] = '{5, 14};
    trigger = 1'b1; rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_off[0] = 1; m_dur[0] = 2;
    write_cfg(CFG_SEL_OFFSET, 0, 1); write_cfg(CFG_SEL_DURATION, 0, 2);
    arm_seq(1); repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL trig_held busy/armed got %b%b exp 01", busy, armed);
    end
    trigger = 1'b0; tick();
    model_plan(1);
    fire();
    for (int c = 1; c <= m_done + 1; c++) begin
      tick();
      checks++;
      if (power_select !== ~exp_low(c) || done !== (c == m_done)) begin
        errors++; $display("FAIL trig_rearm c=%0d ps/done got %b%b exp %b%b", c, power_select, done, ~exp_low(c), c == m_done);
      end
    end
    trigger = 1'b0;
    for (int p = 0; p < 2; p++) begin
      write_cfg(CFG_SEL_OFFSET, 0, 8); write_cfg(CFG_SEL_DURATION, 0, 50);
      arm_seq(1); tick(); fire(); trigger = 1'b0;
      repeat (pos[p]) tick();
      checks++;
      if (busy !== 1'b1 || power_select !== (p == 0)) begin
        errors++; $display("FAIL rst_pre%0d busy/ps got %b%b exp 1%b", p, busy, power_select, p == 0);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({power_select, armed, busy, done, pulse_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
        errors++; $display("FAIL rst_async%0d got %b exp 1000_00", p, {power_select, armed, busy, done, pulse_idx});
      end
      tick(); rst_n = 1'b1; tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_abort();
    test_guards();
    test_trigger_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
